// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : ROM fetch bus plus decode-side presentation bus for inst_fetch.
// Revision    : 1.0
// ============================================================================
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 64
);
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              stall;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;

    modport master (
        output rom_ce, rom_addr, if_valid, if_pc, if_inst,
        input  rom_inst, stall, branch_flag, branch_target
    );

    modport slave (
        input  rom_ce, rom_addr, if_valid, if_pc, if_inst,
        output rom_inst, stall, branch_flag, branch_target
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch front end with prefetch FIFO, stall and
//               branch redirect/flush toward decode.
// Revision    : 1.0
// ============================================================================
module inst_fetch #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 64,
    parameter int PC_STEP    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    inst_fetch_if.master bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic               r_rom_ce;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0]  r_fifo_pc   [FIFO_DEPTH];
    logic [INST_W-1:0]  r_fifo_inst [FIFO_DEPTH];
    logic               r_if_valid;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [INST_W-1:0]  r_if_inst;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop  = !bus.stall && (r_count != '0) && !bus.branch_flag;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push = r_rom_ce && !bus.branch_flag && (!w_full || w_pop);

    assign bus.rom_ce   = r_rom_ce;
    assign bus.rom_addr = r_fetch_pc;
    assign bus.if_valid = r_if_valid;
    assign bus.if_pc    = r_if_pc;
    assign bus.if_inst  = r_if_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_ce   <= 1'b0;
            r_fetch_pc <= '0;
        end else begin
            r_rom_ce <= 1'b1;
            if (bus.branch_flag) begin
                r_fetch_pc <= bus.branch_target;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.branch_flag) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
            r_fifo_inst[r_wr_ptr] <= bus.rom_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= '0;
        end else if (bus.branch_flag) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= '0;
        end else if (!bus.stall) begin
            if (w_pop) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_fifo_pc[r_rd_ptr];
                r_if_inst  <= r_fifo_inst[r_rd_ptr];
            end else begin
                r_if_valid <= 1'b0;
                r_if_inst  <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Randomized scoreboard bench for inst_fetch against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_inst_fetch;
    localparam int ADDR_W = 32;
    localparam int INST_W = 64;
    localparam int DEPTH  = 4;

    typedef struct {
        logic              ce;
        logic [ADDR_W-1:0] addr;
        logic              v;
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    inst_fetch #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .PC_STEP(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [INST_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return 64'h2010800000000400 + 64'(a >> 4);
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_addr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: prefetch buffer as a queue of fetched addresses.
    bit                m_ce;
    logic [ADDR_W-1:0] m_fpc;
    logic [ADDR_W-1:0] m_q[$];
    logic              m_v;
    logic [ADDR_W-1:0] m_pc;
    logic [INST_W-1:0] m_inst;
    exp_t              exp_q[$];

    task automatic model_reset();
        m_ce = 0; m_fpc = '0; m_q.delete();
        m_v = 0; m_pc = '0; m_inst = '0;
        exp_q.delete();
    endtask

    task automatic step(input bit s, input bit bf, input logic [ADDR_W-1:0] bt);
        int  n;
        bit  pop, push;
        exp_t e;
        bus.stall = s; bus.branch_flag = bf; bus.branch_target = bt;
        n    = m_q.size();
        pop  = !s && n > 0 && !bf;
        push = m_ce && !bf && (n < DEPTH || pop);
        if (bf) begin
            m_v = 0; m_inst = '0;
        end else if (!s) begin
            if (pop) begin
                m_v = 1; m_pc = m_q[0]; m_inst = rom_word(m_q[0]);
            end else begin
                m_v = 0; m_inst = '0;
            end
        end
        if (bf) begin
            m_q.delete(); m_fpc = bt;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(m_fpc);
                m_fpc = m_fpc + 32'd16;
            end
        end
        m_ce = 1;
        e.ce = m_ce; e.addr = m_fpc; e.v = m_v; e.pc = m_pc; e.inst = m_inst;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("rom_ce",   64'(bus.rom_ce),   64'(me.ce));
            chk("rom_addr", 64'(bus.rom_addr), 64'(me.addr));
            chk("if_valid", 64'(bus.if_valid), 64'(me.v));
            chk("if_pc",    64'(bus.if_pc),    64'(me.pc));
            chk("if_inst",  bus.if_inst,       me.inst);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_rom_ce"},   64'(bus.rom_ce),   64'd0);
        chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
        chk({tag, "_if_valid"}, 64'(bus.if_valid), 64'd0);
        chk({tag, "_if_pc"},    64'(bus.if_pc),    64'd0);
        chk({tag, "_if_inst"},  bus.if_inst,       64'd0);
    endtask

    task automatic startup(input string tag);
        step(0, 0, '0);
        chk({tag, "_ce_edge1"}, 64'(bus.rom_ce), 64'd1);
        step(0, 0, '0);
        chk({tag, "_valid_edge2"}, 64'(bus.if_valid), 64'd0);
        step(0, 0, '0);
        chk({tag, "_valid_edge3"}, 64'(bus.if_valid), 64'd1);
        chk({tag, "_pc_edge3"},    64'(bus.if_pc),    64'd0);
        chk({tag, "_inst_edge3"},  bus.if_inst,       rom_word(32'd0));
    endtask

    logic [ADDR_W-1:0] held_addr, held_pc;

    initial begin
        model_reset();
        rst = 1'b1;
        bus.stall = 1'($urandom); bus.branch_flag = 1'($urandom);
        bus.branch_target = $urandom;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        bus.branch_flag = 1'b0;
        startup("start");

        // Streaming
        repeat (10) step(0, 0, '0);

        // Stall backpressure
        held_pc = bus.if_pc;
        repeat (4) step(1, 0, '0);
        held_addr = bus.rom_addr;
        repeat (4) step(1, 0, '0);
        chk("stall_addr_frozen", 64'(bus.rom_addr), 64'(held_addr));
        chk("stall_pc_frozen",   64'(bus.if_pc),    64'(held_pc));
        step(0, 0, '0);
        chk("stall_resume_pc", 64'(bus.if_pc), 64'(held_pc + 32'h10));

        // Branch flush while full and stalled
        step(1, 1, 32'h30);
        chk("branch_valid_drop", 64'(bus.if_valid), 64'd0);
        step(0, 0, '0);
        step(0, 0, '0);
        chk("branch_target_pc", 64'(bus.if_pc), 64'h30);
        step(0, 0, '0);
        chk("branch_next_pc", 64'(bus.if_pc), 64'h40);
        step(0, 0, '0);

        // Address wrap
        step(0, 1, 32'hFFFF_FFE0);
        step(0, 0, '0);
        step(0, 0, '0);
        chk("wrap_pc0", 64'(bus.if_pc), 64'hFFFF_FFE0);
        step(0, 0, '0);
        chk("wrap_pc1", 64'(bus.if_pc), 64'hFFFF_FFF0);
        step(0, 0, '0);
        chk("wrap_pc2", 64'(bus.if_pc), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                 $urandom & 32'hFFFF_FFF0);
        end

        // Async reset mid-stream
        repeat (3) step(0, 0, '0);
        chk("pre_reset_valid", 64'(bus.if_valid), 64'd1);
        #2 rst = 1'b1;
        #1 chk_zero("async");
        model_reset();
        bus.stall = 1'($urandom); bus.branch_flag = 1'($urandom);
        @(negedge clk);
        rst = 1'b0;
        bus.branch_flag = 1'b0;
        startup("restart");
        repeat (5) step(0, 0, '0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
